// File: rtl/key_reset_ctrl_pkg.sv
// rtl/key_reset_ctrl_pkg.sv - shared FSM type and constants for the board reset controller
package key_reset_ctrl_pkg;

  // Reset sequencer states: idle, minimum-width stretch, and follow-the-request hold.
  typedef enum logic [1:0] {
    RUN    = 2'd0,
    ASSERT = 2'd1,
    HOLD   = 2'd2
  } rst_state_e;

  // Width of the saturating reset event counter.
  localparam int RESET_COUNT_W = 8;

  // Number of flops in each clock-domain-crossing synchroniser.
  localparam int SYNC_DEPTH = 2;

  // Bits needed to hold a down/up counter spanning 0 .. n-1 (never narrower than 1).
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/key_debouncer.sv
// rtl/key_debouncer.sv - push-button synchroniser, debounce counter and pressed-level register
module key_debouncer
  import key_reset_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter bit KEY_ACTIVE_LOW  = 1'b1
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic key_i,
  output logic key_pressed_o
);

  localparam int            CW       = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
  // Level the raw pin rests at when nobody touches the button.
  localparam logic          KEY_IDLE = KEY_ACTIVE_LOW;

  logic [SYNC_DEPTH-1:0] sync_q;
  logic                  key_now_pressed;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  key_pressed_q, key_pressed_d;

  // Bring the raw button into the clock domain; the chain resets to the idle level.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= {SYNC_DEPTH{KEY_IDLE}};
    end else begin
      sync_q <= {sync_q[SYNC_DEPTH-2:0], key_i};
    end
  end

  // Normalise polarity so 1 always means "pressed" downstream.
  assign key_now_pressed = sync_q[SYNC_DEPTH-1] ^ KEY_IDLE;

  // Count consecutive cycles of disagreement; any agreement restarts the window.
  always_comb begin
    cnt_d         = cnt_q;
    key_pressed_d = key_pressed_q;
    if (key_now_pressed != key_pressed_q) begin
      if (cnt_q == CNT_LAST) begin
        key_pressed_d = ~key_pressed_q;
        cnt_d         = '0;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end else begin
      cnt_d = '0;
    end
  end

  // Debounce state registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q         <= '0;
      key_pressed_q <= 1'b0;
    end else begin
      cnt_q         <= cnt_d;
      key_pressed_q <= key_pressed_d;
    end
  end

  assign key_pressed_o = key_pressed_q;

endmodule

// File: rtl/key_reset_ctrl.sv
// rtl/key_reset_ctrl.sv - key/JTAG driven SoC reset sequencer with stretch, hold and event count (KEY_RESET_CTRL_JTAG_EN enables the jtag path)
module key_reset_ctrl
  import key_reset_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int STRETCH_CYCLES  = 16,
  parameter bit KEY_ACTIVE_LOW  = 1'b1
) (
  input  logic                     ss_clk_in,
  input  logic                     ss_reset_n_in,
  input  logic                     key_in,
  input  logic                     jtag_reset_in,
  output logic                     soc_reset_o,
  output logic                     reset_led_o,
  output logic                     key_pressed_o,
  output logic [RESET_COUNT_W-1:0] reset_count_o
);

  localparam int            SW           = cnt_width(STRETCH_CYCLES);
  localparam logic [SW-1:0] STRETCH_LOAD = SW'(STRETCH_CYCLES - 1);

  logic                     key_pressed;
  logic                     jtag_sync;
  logic                     req;
  rst_state_e               state_q;
  logic [SW-1:0]            stretch_q;
  logic [RESET_COUNT_W-1:0] count_q;
  logic                     soc_reset_q;

  key_debouncer #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .KEY_ACTIVE_LOW  (KEY_ACTIVE_LOW)
  ) u_key_debouncer (
    .clk_i         (ss_clk_in),
    .rst_ni        (ss_reset_n_in),
    .key_i         (key_in),
    .key_pressed_o (key_pressed)
  );

`ifdef KEY_RESET_CTRL_JTAG_EN
  logic [SYNC_DEPTH-1:0] jtag_sync_q;

  // Two-flop synchroniser for the asynchronous in-system-source reset request.
  always_ff @(posedge ss_clk_in or negedge ss_reset_n_in) begin
    if (!ss_reset_n_in) begin
      jtag_sync_q <= '0;
    end else begin
      jtag_sync_q <= {jtag_sync_q[SYNC_DEPTH-2:0], jtag_reset_in};
    end
  end

  assign jtag_sync = jtag_sync_q[SYNC_DEPTH-1];
`else
  // Without the jtag path the pin is kept on the port but has no effect.
  logic unused_jtag;
  assign unused_jtag = jtag_reset_in;
  assign jtag_sync   = 1'b0;
`endif

  assign req = key_pressed | jtag_sync;

  // Reset sequencer: a new request from RUN is one event; the pulse is at least
  // STRETCH_CYCLES wide and then follows req until it drops. soc_reset_q mirrors
  // the next state so the output is a plain flop and cannot glitch.
  always_ff @(posedge ss_clk_in or negedge ss_reset_n_in) begin
    if (!ss_reset_n_in) begin
      state_q     <= ASSERT;
      stretch_q   <= STRETCH_LOAD;
      count_q     <= '0;
      soc_reset_q <= 1'b1;
    end else begin
      case (state_q)
        RUN: begin
          if (req) begin
            state_q     <= ASSERT;
            stretch_q   <= STRETCH_LOAD;
            soc_reset_q <= 1'b1;
            if (count_q != '1) begin
              count_q <= count_q + 1'b1;
            end
          end else begin
            soc_reset_q <= 1'b0;
          end
        end
        ASSERT: begin
          if (stretch_q == '0) begin
            if (req) begin
              state_q     <= HOLD;
              soc_reset_q <= 1'b1;
            end else begin
              state_q     <= RUN;
              soc_reset_q <= 1'b0;
            end
          end else begin
            stretch_q   <= stretch_q - 1'b1;
            soc_reset_q <= 1'b1;
          end
        end
        HOLD: begin
          if (!req) begin
            state_q     <= RUN;
            soc_reset_q <= 1'b0;
          end else begin
            soc_reset_q <= 1'b1;
          end
        end
        default: begin
          state_q     <= RUN;
          soc_reset_q <= 1'b0;
        end
      endcase
    end
  end

  assign soc_reset_o   = soc_reset_q;
  assign reset_led_o   = soc_reset_q;
  assign key_pressed_o = key_pressed;
  assign reset_count_o = count_q;

endmodule

// File: tb/tb_key_reset_ctrl.sv
// tb/tb_key_reset_ctrl.sv - directed self-checking bench for key_reset_ctrl
module tb_key_reset_ctrl;

  logic       clk;
  logic       rst_n;
  logic       key;
  logic       jtag;
  logic       soc_reset;
  logic       reset_led;
  logic       key_pressed;
  logic [7:0] reset_count;

  int total;
  int bad;
  int exp_cnt;

  key_reset_ctrl #(
    .DEBOUNCE_CYCLES (8),
    .STRETCH_CYCLES  (4),
    .KEY_ACTIVE_LOW  (1'b1)
  ) dut (
    .ss_clk_in     (clk),
    .ss_reset_n_in (rst_n),
    .key_in        (key),
    .jtag_reset_in (jtag),
    .soc_reset_o   (soc_reset),
    .reset_led_o   (reset_led),
    .key_pressed_o (key_pressed),
    .reset_count_o (reset_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    total++;
    assert (obs === exp_v) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
    end
  endtask

  initial begin
    total   = 0;
    bad     = 0;
    exp_cnt = 0;
    rst_n   = 1'b0;
    key     = 1'b1;
    jtag    = 1'b0;

    // Power-on reset held for three edges.
    tick(3);
    chk("por_soc", 32'(soc_reset), 32'd1);
    chk("por_led", 32'(reset_led), 32'd1);
    chk("por_key", 32'(key_pressed), 32'd0);
    chk("por_cnt", 32'(reset_count), 32'd0);

    // Release: high now plus three more edges (four cycles), low on the fourth edge.
    rst_n = 1'b1;
    chk("rel_soc_0", 32'(soc_reset), 32'd1);
    for (int i = 1; i <= 5; i++) begin
      tick(1);
      chk($sformatf("rel_soc_%0d", i), 32'(soc_reset), (i <= 3) ? 32'd1 : 32'd0);
    end
    chk("rel_cnt", 32'(reset_count), 32'd0);
    chk("rel_led", 32'(reset_led), 32'd0);

    // Bounce: key toggles every three cycles, never stable long enough.
    for (int t = 0; t < 10; t++) begin
      key = ~key;
      for (int c = 0; c < 3; c++) begin
        tick(1);
        chk("bounce_key", 32'(key_pressed), 32'd0);
        chk("bounce_soc", 32'(soc_reset), 32'd0);
      end
    end
    tick(6);
    chk("bounce_cnt", 32'(reset_count), 32'd0);

    // Clean press: debounced at edge 10, reset at edge 11.
    key = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      tick(1);
      chk($sformatf("press_key_%0d", k), 32'(key_pressed), (k >= 10) ? 32'd1 : 32'd0);
      chk($sformatf("press_soc_%0d", k), 32'(soc_reset), (k >= 11) ? 32'd1 : 32'd0);
    end
    exp_cnt = 1;
    chk("press_cnt", 32'(reset_count), 32'(exp_cnt));

    // Release: key falls at edge 10, reset one edge later (held in HOLD).
    key = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      tick(1);
      chk($sformatf("release_key_%0d", k), 32'(key_pressed), (k < 10) ? 32'd1 : 32'd0);
      chk($sformatf("release_soc_%0d", k), 32'(soc_reset), (k < 11) ? 32'd1 : 32'd0);
    end
    chk("release_cnt", 32'(reset_count), 32'(exp_cnt));

`ifdef KEY_RESET_CTRL_JTAG_EN
    // Single-cycle jtag request: seen at edge 3, exactly four cycles of reset.
    jtag = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      tick(1);
      if (k == 1) jtag = 1'b0;
      chk($sformatf("jtag_soc_%0d", k), 32'(soc_reset), (k >= 3 && k <= 6) ? 32'd1 : 32'd0);
    end
    exp_cnt++;
    chk("jtag_cnt", 32'(reset_count), 32'(exp_cnt));
`else
    // Jtag path absent: a jtag pulse must be ignored.
    jtag = 1'b1;
    tick(1);
    jtag = 1'b0;
    tick(7);
    chk("jtag_off_soc", 32'(soc_reset), 32'd0);
    chk("jtag_off_cnt", 32'(reset_count), 32'(exp_cnt));
`endif
    tick(4);

    // Key and jtag together, jtag held until the key is debounced, then a jtag re-pulse in HOLD.
    key  = 1'b0;
    jtag = 1'b1;
    tick(12);
    jtag = 1'b0;
    chk("sim_soc_a", 32'(soc_reset), 32'd1);
    chk("sim_key", 32'(key_pressed), 32'd1);
    tick(8);
    jtag = 1'b1;
    tick(1);
    jtag = 1'b0;
    tick(5);
    chk("sim_soc_b", 32'(soc_reset), 32'd1);
    chk("sim_cnt_hold", 32'(reset_count), 32'(exp_cnt + 1));
    key = 1'b1;
    tick(12);
    exp_cnt++;
    chk("sim_soc_end", 32'(soc_reset), 32'd0);
    chk("sim_key_end", 32'(key_pressed), 32'd0);
    chk("sim_cnt", 32'(reset_count), 32'(exp_cnt));

    // Saturation: 260 more events must stop the counter at 255.
    for (int p = 0; p < 260; p++) begin
`ifdef KEY_RESET_CTRL_JTAG_EN
      jtag = 1'b1;
      tick(1);
      jtag = 1'b0;
      tick(9);
`else
      key = 1'b0;
      tick(14);
      key = 1'b1;
      tick(14);
`endif
    end
    chk("sat_cnt", 32'(reset_count), 32'd255);
    chk("sat_soc", 32'(soc_reset), 32'd0);

    // Mid-operation reset takes effect before the next clock edge.
    tick(1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_soc", 32'(soc_reset), 32'd1);
    chk("mid_led", 32'(reset_led), 32'd1);
    chk("mid_cnt", 32'(reset_count), 32'd0);
    chk("mid_key", 32'(key_pressed), 32'd0);
    tick(2);
    rst_n = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      tick(1);
      chk($sformatf("mid_rel_soc_%0d", i), 32'(soc_reset), (i <= 3) ? 32'd1 : 32'd0);
    end
    chk("mid_rel_cnt", 32'(reset_count), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
